// File: rtl/attn_row_sequencer_if.sv
// Stream bundle for attn_row_sequencer: slave operand stream in, master exp stream out.
// Optional ATTN_SEQ_MAX_EN adds the m_max row-maximum signal.
interface attn_row_sequencer_if #(
    parameter int EXW  = 9,
    parameter int SUMW = 11
);
    logic [7:0]      s_data;
    logic            s_vld;
    logic            s_rdy;
    logic [EXW-1:0]  m_data;
    logic            m_vld;
    logic            m_rdy;
    logic            m_last;
    logic [SUMW-1:0] m_sum;
`ifdef ATTN_SEQ_MAX_EN
    logic [EXW-1:0]  m_max;

    modport slave  (input  s_data, s_vld, m_rdy,
                    output s_rdy, m_data, m_vld, m_last, m_sum, m_max);
    modport master (output s_data, s_vld, m_rdy,
                    input  s_rdy, m_data, m_vld, m_last, m_sum, m_max);
`else
    modport slave  (input  s_data, s_vld, m_rdy,
                    output s_rdy, m_data, m_vld, m_last, m_sum);
    modport master (output s_data, s_vld, m_rdy,
                    input  s_rdy, m_data, m_vld, m_last, m_sum);
`endif
endinterface

// File: rtl/attn_row_sequencer.sv
// Sequences the shared Q0.7 MAC / e^x datapath over one attention row and drains the exp buffer.
// Optional ATTN_SEQ_MAX_EN tracks the unsigned maximum of the row's exp values on m_max.
//
// state  | meaning
// LOAD_A | wait for q operand byte
// LOAD_B | wait for k operand byte
// MAC    | one accumulate strobe for the loaded pair
// EXP    | capture exp result into buffer, clear accumulator
// DRAIN  | stream buffered exp values with row sum
module attn_row_sequencer #(
    parameter int N_FEAT = 4,
    parameter int N_KEYS = 4,
    parameter int EXW    = 9,
    parameter int SUMW   = EXW + $clog2(N_KEYS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    attn_row_sequencer_if.slave    bus,
    output logic [7:0]             mac_a_o,
    output logic [7:0]             mac_b_o,
    output logic                   mac_en_o,
    output logic                   mac_clr_o,
    input  logic [EXW-1:0]         ex_val_i
);

    localparam int FW    = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
    localparam int KW    = (N_KEYS > 1) ? $clog2(N_KEYS) : 1;
    localparam int DEPTH = 1 << KW;
    localparam logic [FW-1:0] FEAT_LAST = FW'(N_FEAT - 1);
    localparam logic [KW-1:0] KEY_LAST  = KW'(N_KEYS - 1);

    typedef enum logic [2:0] {
        LOAD_A = 3'd0,
        LOAD_B = 3'd1,
        MAC    = 3'd2,
        EXP    = 3'd3,
        DRAIN  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [FW-1:0]   feat_cnt_q, feat_cnt_d;
    logic [KW-1:0]   key_cnt_q, key_cnt_d;
    logic [KW-1:0]   out_cnt_q, out_cnt_d;
    logic [7:0]      mac_a_q, mac_a_d;
    logic [7:0]      mac_b_q, mac_b_d;
    logic [SUMW-1:0] sum_q, sum_d;
    logic            buf_we;
    logic [EXW-1:0]  buf_q [DEPTH];
`ifdef ATTN_SEQ_MAX_EN
    logic [EXW-1:0]  max_q, max_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= LOAD_A;
            feat_cnt_q <= '0;
            key_cnt_q  <= '0;
            out_cnt_q  <= '0;
            mac_a_q    <= '0;
            mac_b_q    <= '0;
            sum_q      <= '0;
`ifdef ATTN_SEQ_MAX_EN
            max_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            feat_cnt_q <= feat_cnt_d;
            key_cnt_q  <= key_cnt_d;
            out_cnt_q  <= out_cnt_d;
            mac_a_q    <= mac_a_d;
            mac_b_q    <= mac_b_d;
            sum_q      <= sum_d;
`ifdef ATTN_SEQ_MAX_EN
            max_q      <= max_d;
`endif
        end
    end

    // Buffer is never observable outside DRAIN, so it needs no reset.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_q[key_cnt_q] <= ex_val_i;
        end
    end

    always_comb begin
        state_d    = state_q;
        feat_cnt_d = feat_cnt_q;
        key_cnt_d  = key_cnt_q;
        out_cnt_d  = out_cnt_q;
        mac_a_d    = mac_a_q;
        mac_b_d    = mac_b_q;
        sum_d      = sum_q;
        buf_we     = 1'b0;
`ifdef ATTN_SEQ_MAX_EN
        max_d      = max_q;
`endif
        case (state_q)
            LOAD_A: begin
                if (bus.s_vld) begin
                    mac_a_d = bus.s_data;
                    state_d = LOAD_B;
                end
            end
            LOAD_B: begin
                if (bus.s_vld) begin
                    mac_b_d = bus.s_data;
                    state_d = MAC;
                end
            end
            MAC: begin
                if (feat_cnt_q == FEAT_LAST) begin
                    feat_cnt_d = '0;
                    state_d    = EXP;
                end else begin
                    feat_cnt_d = feat_cnt_q + 1'b1;
                    state_d    = LOAD_A;
                end
            end
            EXP: begin
                buf_we = 1'b1;
                sum_d  = sum_q + SUMW'(ex_val_i);
`ifdef ATTN_SEQ_MAX_EN
                if (ex_val_i > max_q) begin
                    max_d = ex_val_i;
                end
`endif
                if (key_cnt_q == KEY_LAST) begin
                    key_cnt_d = '0;
                    state_d   = DRAIN;
                end else begin
                    key_cnt_d = key_cnt_q + 1'b1;
                    state_d   = LOAD_A;
                end
            end
            DRAIN: begin
                if (bus.m_rdy) begin
                    if (out_cnt_q == KEY_LAST) begin
                        out_cnt_d = '0;
                        sum_d     = '0;
`ifdef ATTN_SEQ_MAX_EN
                        max_d     = '0;
`endif
                        state_d   = LOAD_A;
                    end else begin
                        out_cnt_d = out_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = LOAD_A;
        endcase
    end

    // Every output decodes from registered state only.
    assign bus.s_rdy  = (state_q == LOAD_A) || (state_q == LOAD_B);
    assign bus.m_vld  = (state_q == DRAIN);
    assign bus.m_last = (state_q == DRAIN) && (out_cnt_q == KEY_LAST);
    assign bus.m_data = (state_q == DRAIN) ? buf_q[out_cnt_q] : '0;
    assign bus.m_sum  = sum_q;
`ifdef ATTN_SEQ_MAX_EN
    assign bus.m_max  = max_q;
`endif
    assign mac_a_o    = mac_a_q;
    assign mac_b_o    = mac_b_q;
    assign mac_en_o   = (state_q == MAC);
    assign mac_clr_o  = (state_q == EXP);

endmodule
